// File: rtl/mx_conv_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mx_conv_arbiter_if
// Brief    : Requester, converter and response bundle for mx_conv_arbiter.
// Revision : 1.0
// ============================================================================
interface mx_conv_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int BIT_WIDTH = 6,
  parameter int ID_W      = $clog2(N_REQ)
);
  logic [N_REQ-1:0]                i_req_valid;
  logic [N_REQ-1:0]                o_req_ready;
  logic [N_REQ-1:0][31:0][15:0]    i_req_vec;
  logic [31:0][15:0]               o_conv_vec;
  logic [31:0][BIT_WIDTH-1:0]      i_conv_mx_vec;
  logic [7:0]                      i_conv_mx_exp;
  logic                            o_rsp_valid;
  logic [ID_W-1:0]                 o_rsp_id;
  logic [31:0][BIT_WIDTH-1:0]      o_rsp_mx_vec;
  logic [7:0]                      o_rsp_exp;

  modport master (
    input  i_req_valid, i_req_vec, i_conv_mx_vec, i_conv_mx_exp,
    output o_req_ready, o_conv_vec, o_rsp_valid, o_rsp_id, o_rsp_mx_vec, o_rsp_exp
  );

  modport slave (
    output i_req_valid, i_req_vec, i_conv_mx_vec, i_conv_mx_exp,
    input  o_req_ready, o_conv_vec, o_rsp_valid, o_rsp_id, o_rsp_mx_vec, o_rsp_exp
  );
endinterface
`default_nettype wire

// File: rtl/mx_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mx_conv_arbiter
// Brief    : Round-robin issue of bf16 blocks into a fixed-latency MX converter
//            with tagged responses. MX_CONV_ARB_PERF_EN adds perf counters.
// Revision : 1.0
// ============================================================================
module mx_conv_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ID_W         = $clog2(N_REQ),
  parameter int CONV_LATENCY = 4,
  parameter int BIT_WIDTH    = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  mx_conv_arbiter_if.master        bus
`ifdef MX_CONV_ARB_PERF_EN
  ,
  output logic [N_REQ-1:0][31:0]   o_grant_cnt,
  output logic [31:0]              o_idle_cnt
`endif
);

  logic [ID_W-1:0]         r_ptr;
  logic [ID_W:0]           w_idx;
  logic                    w_found;
  logic [ID_W-1:0]         w_gnt_id;
  logic [N_REQ-1:0]        w_ready;
  logic                    w_hs;
  logic [31:0][15:0]       r_conv_vec;
  logic [CONV_LATENCY:0]   r_tag_vld;
  logic [ID_W-1:0]         r_tag_id [CONV_LATENCY+1];

  // Rotating search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(N_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(N_REQ);
      end
      if (!w_found && bus.i_req_valid[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_hs = w_found & ~i_rst;

  always_comb begin
    w_ready = '0;
    if (w_hs) begin
      w_ready[w_gnt_id] = 1'b1;
    end
  end

  assign bus.o_req_ready = w_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_conv_vec <= '0;
    end else if (w_hs) begin
      r_ptr      <= (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
      r_conv_vec <= bus.i_req_vec[w_gnt_id];
    end
  end

  assign bus.o_conv_vec = r_conv_vec;

  // Tags travel alongside the free-running converter; only tagged slots emit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      for (int s = 0; s <= CONV_LATENCY; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld   <= {r_tag_vld[CONV_LATENCY-1:0], w_hs};
      r_tag_id[0] <= w_gnt_id;
      for (int s = 1; s <= CONV_LATENCY; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  assign bus.o_rsp_valid  = r_tag_vld[CONV_LATENCY];
  assign bus.o_rsp_id     = r_tag_id[CONV_LATENCY];
  assign bus.o_rsp_mx_vec = bus.i_conv_mx_vec;
  assign bus.o_rsp_exp    = bus.i_conv_mx_exp;

`ifdef MX_CONV_ARB_PERF_EN
  logic [31:0] r_idle_cnt;

  for (genvar n = 0; n < N_REQ; n++) begin : g_grant_cnt
    logic [31:0] r_cnt;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_cnt <= '0;
      end else if (w_hs && (w_gnt_id == ID_W'(n))) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
    assign o_grant_cnt[n] = r_cnt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idle_cnt <= '0;
    end else if (bus.i_req_valid == '0) begin
      r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end

  assign o_idle_cnt = r_idle_cnt;
`endif

endmodule
`default_nettype wire
